run_sequencer: RTL

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_pkg.sv | 27 ++
 rtl/run_counter.sv | 35 +++
 rtl/run_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/run_pkg.sv
// Shared types and constants for the run sequencer: FSM state encoding,
// default program-counter width and the program start-address table.
package run_pkg;

  localparam int PC_WIDTH  = 12;
  localparam int NUM_PROGS = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } run_state_t;

  // Start address of each selectable program.
  function automatic logic [PC_WIDTH-1:0] prog_base(input logic [1:0] sel);
    logic [PC_WIDTH-1:0] base;
    case (sel)
      2'd0:    base = 12'h000;
      2'd1:    base = 12'h040;
      2'd2:    base = 12'h100;
      default: base = 12'h200;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Run-length counter: synchronous clear, count enable, saturates at MAX_CYCLES
// and flags when the cycle being counted now is the last one allowed.
module run_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_CYCLES  = 50000
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_enable,
  output logic [COUNT_WIDTH-1:0] o_next_count,
  output logic                   o_at_limit
);

  localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_CYCLES);

  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_next;

  // r_count holds completed RUN cycles; w_next is the number of the current one.
  assign w_next       = (r_count == MAX_VAL) ? MAX_VAL : r_count + 1'b1;
  assign o_next_count = w_next;
  assign o_at_limit   = (w_next == MAX_VAL);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Launches a program on an attached core, times the run against MAX_CYCLES
// and reports completion, timeout, run length and a completed-run count.
module run_sequencer #(
  parameter int PC_WIDTH    = run_pkg::PC_WIDTH,
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_CYCLES  = 50000,
  parameter int REQ_CYCLES  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             prog_sel,
  output logic                   core_req,
  input  logic                   core_done,
  output logic [PC_WIDTH-1:0]    pc_base,
  output logic                   busy,
  output logic                   run_done,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic [7:0]             runs_completed,
  output logic [1:0]             dbg_state
);

  import run_pkg::*;

  localparam int LW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [LW-1:0] LAUNCH_LAST = LW'(REQ_CYCLES - 1);

  run_state_t              r_state;
  logic                    r_core_req;
  logic                    r_run_done;
  logic                    r_timeout;
  logic [COUNT_WIDTH-1:0]  r_cycle_count;
  logic [7:0]              r_runs;
  logic [PC_WIDTH-1:0]     r_pc_base;
  logic [LW-1:0]           r_launch_cnt;

  logic                    w_launch;
  logic                    w_cnt_enable;
  logic [COUNT_WIDTH-1:0]  w_next_count;
  logic                    w_at_limit;

  assign w_launch     = (r_state == S_IDLE) && start;
  assign w_cnt_enable = (r_state == S_RUN);

  run_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .MAX_CYCLES  (MAX_CYCLES)
  ) u_counter (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_clear      (w_launch),
    .i_enable     (w_cnt_enable),
    .o_next_count (w_next_count),
    .o_at_limit   (w_at_limit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_core_req    <= 1'b0;
      r_run_done    <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_runs        <= '0;
      r_pc_base     <= PC_WIDTH'(prog_base(2'd0));
      r_launch_cnt  <= '0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LAUNCH;
            r_core_req   <= 1'b1;
            r_launch_cnt <= '0;
            r_timeout    <= 1'b0;
            r_pc_base    <= PC_WIDTH'(prog_base(prog_sel));
          end
        end
        // core_done is deliberately not looked at here: it may still be
        // asserted from the previous program.
        S_LAUNCH: begin
          if (r_launch_cnt == LAUNCH_LAST) begin
            r_state    <= S_RUN;
            r_core_req <= 1'b0;
          end else begin
            r_launch_cnt <= r_launch_cnt + 1'b1;
          end
        end
        // Done on the limit cycle counts as a normal completion.
        S_RUN: begin
          if (core_done) begin
            r_state       <= S_FINISH;
            r_run_done    <= 1'b1;
            r_cycle_count <= w_next_count;
            r_runs        <= r_runs + 1'b1;
          end else if (w_at_limit) begin
            r_state       <= S_FINISH;
            r_run_done    <= 1'b1;
            r_timeout     <= 1'b1;
            r_cycle_count <= w_next_count;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_req       = r_core_req;
  assign busy           = (r_state != S_IDLE);
  assign run_done       = r_run_done;
  assign timeout        = r_timeout;
  assign cycle_count    = r_cycle_count;
  assign runs_completed = r_runs;
  assign pc_base        = r_pc_base;
  assign dbg_state      = r_state;

endmodule
